// File: rtl/bictr_dcnto_step.sv
// Up/down counter with dynamic bounds, step size and four terminal modes.
// Define BICTR_DCNTO_STEP_EN to honour the step port (else step is 1).
module bictr_dcnto_step #(
  parameter int width  = 8,
  parameter int step_w = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [width-1:0]  data,
  input  logic [width-1:0]  count_to,
  input  logic [width-1:0]  count_from,
  input  logic [step_w-1:0] step,
  input  logic              up_dn,
  input  logic              load,
  input  logic              cen,
  input  logic [1:0]        mode,
  input  logic              clr_halt,
  output logic [width-1:0]  count,
  output logic              tercnt,
  output logic              wrap_pulse,
  output logic              halted
);

  localparam logic [0:0] RUN    = 1'b0;
  localparam logic [0:0] HALTED = 1'b1;

  logic [0:0]       state;
  logic [width-1:0] s_w;
  logic [width:0]   s_ext;
  logic [width:0]   c_ext;
  logic [width:0]   up_nxt;
  logic [width:0]   dn_lim;
  logic [width-1:0] dn_nxt;
  logic             up_term;
  logic             dn_term;
  logic             term;
  logic             cnt_en;
  logic [width-1:0] term_val;

`ifdef BICTR_DCNTO_STEP_EN
  assign s_w = width'(step);
`else
  logic unused_step;
  assign unused_step = ^step;
  assign s_w = width'(1);
`endif

  assign s_ext   = {1'b0, s_w};
  assign c_ext   = {1'b0, count};
  assign up_nxt  = c_ext + s_ext;
  assign dn_lim  = {1'b0, count_from} + s_ext;
  assign dn_nxt  = count - s_w;
  // width+1 compare keeps an overflowing step a terminal event
  assign up_term = up_nxt >= {1'b0, count_to};
  assign dn_term = c_ext < dn_lim;
  assign term    = up_dn ? up_term : dn_term;
  assign cnt_en  = (state == RUN) && cen && (s_w != '0);

  assign tercnt = up_dn ? (count == count_to)
                        : (count == count_from);

  always_comb begin
    term_val = count;
    unique case (mode)
      2'd0:    term_val = data;
      2'd1:    term_val = up_dn ? count_from : count_to;
      default: term_val = up_dn ? count_to : count_from;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count      <= '0;
      wrap_pulse <= 1'b0;
      state      <= RUN;
    end else if (load) begin
      count      <= data;
      wrap_pulse <= 1'b0;
      state      <= RUN;
    end else if (clr_halt) begin
      wrap_pulse <= 1'b0;
      state      <= RUN;
    end else if (cnt_en) begin
      if (term) begin
        count      <= term_val;
        wrap_pulse <= 1'b1;
        if (mode == 2'd3)
          state <= HALTED;
      end else begin
        count      <= up_dn ? up_nxt[width-1:0] : dn_nxt;
        wrap_pulse <= 1'b0;
      end
    end else begin
      wrap_pulse <= 1'b0;
    end
  end

  assign halted = (state == HALTED);

endmodule

// File: tb/tb_bictr_dcnto_step.sv
// Scoreboard bench for bictr_dcnto_step.
// Expected results come from a behavioural model of the counter.
module tb_bictr_dcnto_step;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data, count_to, count_from;
  logic [3:0] step;
  logic       up_dn, load, cen, clr_halt;
  logic [1:0] mode;
  logic [7:0] count;
  logic       tercnt, wrap_pulse, halted;

  typedef struct packed {
    logic [7:0] c;
    logic       w;
    logic       h;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_cnt;
  bit   m_wrap, m_halt;

  always #5 clk = ~clk;

  bictr_dcnto_step #(.width(8), .step_w(4)) dut (
    .clk(clk), .reset(reset), .data(data),
    .count_to(count_to), .count_from(count_from),
    .step(step), .up_dn(up_dn), .load(load),
    .cen(cen), .mode(mode), .clr_halt(clr_halt),
    .count(count), .tercnt(tercnt),
    .wrap_pulse(wrap_pulse), .halted(halted)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h",
               tag, got, want);
    end
  endtask

  function automatic int eff_step();
`ifdef BICTR_DCNTO_STEP_EN
    return int'(step);
`else
    return 1;
`endif
  endfunction

  task automatic model_step();
    int  s, n;
    bit  t;
    if (load) begin
      m_cnt = int'(data); m_halt = 0; m_wrap = 0;
    end else if (clr_halt) begin
      m_halt = 0; m_wrap = 0;
    end else if (!m_halt && cen && eff_step() != 0) begin
      s = eff_step();
      if (up_dn) begin
        n = m_cnt + s;
        t = (n >= int'(count_to));
      end else begin
        n = m_cnt - s;
        t = (m_cnt < int'(count_from) + s);
      end
      if (t) begin
        case (mode)
          2'd0: m_cnt = int'(data);
          2'd1: m_cnt = up_dn ? int'(count_from) : int'(count_to);
          default: m_cnt = up_dn ? int'(count_to) : int'(count_from);
        endcase
        if (mode == 2'd3) m_halt = 1;
        m_wrap = 1;
      end else begin
        m_cnt = n; m_wrap = 0;
      end
    end else begin
      m_wrap = 0;
    end
    exp_q.push_back('{c: m_cnt[7:0], w: m_wrap, h: m_halt});
  endtask

  task automatic run_cyc();
    exp_t e;
    #1;
    chk("tercnt", {31'd0, tercnt},
        {31'd0, up_dn ? (m_cnt == int'(count_to))
                      : (m_cnt == int'(count_from))});
    model_step();
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("queue_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("count",  {24'd0, count},      {24'd0, e.c});
      chk("wrap",   {31'd0, wrap_pulse}, {31'd0, e.w});
      chk("halted", {31'd0, halted},     {31'd0, e.h});
    end
  endtask

  task automatic do_load(input logic [7:0] d);
    load = 1; data = d; cen = 0; clr_halt = 0;
    run_cyc();
    load = 0;
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) run_cyc();
  endtask

  initial begin
    reset = 1; data = 0; count_to = 0; count_from = 0;
    step = 0; up_dn = 1; load = 0; cen = 0;
    mode = 0; clr_halt = 0;
    m_cnt = 0; m_wrap = 0; m_halt = 0;
    @(posedge clk); #1;
    chk("rst_count",  {24'd0, count}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_wrap",   {31'd0, wrap_pulse}, 32'd0);
    reset = 0;

    // asynchronous reset mid-count
    count_to = 8'hF0; step = 4'd1; up_dn = 1;
    do_load(8'h36);
    cen = 1; run_cyc();
    chk("pre_rst", {24'd0, count}, 32'd0 + m_cnt);
    #2 reset = 1; #1;
    chk("arst_count",  {24'd0, count}, 32'd0);
    chk("arst_halted", {31'd0, halted}, 32'd0);
    chk("arst_wrap",   {31'd0, wrap_pulse}, 32'd0);
    m_cnt = 0; m_wrap = 0; m_halt = 0;
    @(posedge clk); #1 reset = 0;

    // mode 0 up
    mode = 0; count_to = 8'h20; step = 4'd4; up_dn = 1;
    do_load(8'h10);
    cen = 1; run_n(20);

    // mode 1 down
    mode = 1; count_from = 8'h05; count_to = 8'h40;
    step = 4'd3; up_dn = 0;
    do_load(8'h09);
    cen = 1; run_n(7);

    // mode 2 up saturate
    mode = 2; count_to = 8'hFE; step = 4'd5; up_dn = 1;
    do_load(8'hFB);
    cen = 1; run_n(6);

    // mode 3 halt and release
    mode = 3; count_to = 8'h08; step = 4'd1; up_dn = 1;
    do_load(8'h06);
    cen = 1; run_n(5);
    chk("halt_hold", {24'd0, count}, 32'h08);
    clr_halt = 1; run_cyc(); clr_halt = 0;
    chk("clr_count", {24'd0, count}, 32'h08);
    run_n(2);

    // priority: load over clr_halt over cen while halted
    load = 1; clr_halt = 1; cen = 1; data = 8'hAA;
    run_cyc();
    chk("prio_count", {24'd0, count}, 32'hAA);
    load = 0; clr_halt = 0;
    mode = 0; count_to = 8'hF0; step = 4'd0;
    run_n(3);

    // randomised traffic
    for (int i = 0; i < 300; i++) begin
      data       = 8'($urandom);
      count_to   = 8'($urandom);
      count_from = 8'($urandom);
      step       = 4'($urandom);
      up_dn      = 1'($urandom);
      mode       = 2'($urandom);
      load       = ($urandom_range(0, 9) == 0);
      clr_halt   = ($urandom_range(0, 7) == 0);
      cen        = ($urandom_range(0, 3) != 0);
      run_cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
